rv32_mod_decode_stage: RTL and testbench

//  Registered RV32I(+M) decode stage between fetch and execute. Accepts {pc, instr} over a

---
 rtl/rv32_mod_decode_stage.sv | 168 ++++++++++++++++
 tb/tb_rv32_mod_decode_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_decode_stage.sv
// rv32_mod_decode_stage: registered RV32I(+M) decode stage with optional two-entry skid buffer
module rv32_mod_decode_stage #(
  parameter int PC_W     = 32,
  parameter bit SKID     = 1'b1,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [31:0]     imm_o,
  output logic            rf_write0_enable,
  output logic            alu_op0_use_pc,
  output logic            alu_op1_use_imm,
  output logic [4:0]      alu_func,
  output logic [3:0]      ram_special,
  output logic            ram_wr,
  output logic [1:0]      wb_source,
  output logic [2:0]      br_cond,
  output logic            br_is_cond,
  output logic            br_unsigned,
  output logic            br_jmp,
  output logic            illegal_o
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            rf_we;
    logic            use_pc;
    logic            use_imm;
    logic [4:0]      alu_func;
    logic [3:0]      ram_special;
    logic            ram_wr;
    logic [1:0]      wb_source;
    logic [2:0]      br_cond;
    logic            br_is_cond;
    logic            br_unsigned;
    logic            br_jmp;
    logic            illegal;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op, is_fence;
  logic m_op, opimm_ok, op_ok, ld_ok, legal, sub;
  bundle_t dec, out_r, out_n, skid_r, skid_n;
  state_t state, state_n;
  logic rdy_q, acc_in, acc_out;
  assign opc = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign is_br = opc == 7'b1100011;
  assign is_load = opc == 7'b0000011;
  assign is_store = opc == 7'b0100011;
  assign is_opimm = opc == 7'b0010011;
  assign is_op = opc == 7'b0110011;
  assign is_fence = opc == 7'b0001111;
  assign m_op = f7 == 7'b0000001;
  assign ld_ok = f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
  assign opimm_ok = f3 == 3'b001 ? f7 == 7'd0 : f3 == 3'b101 ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1;
  assign op_ok = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (m_op && ENABLE_M);
  assign legal = instr_i[1:0] == 2'b11 && (is_lui || is_auipc || is_jal || (is_jalr && f3 == 3'b000) ||
                 (is_br && f3[2:1] != 2'b01) || (is_load && ld_ok) || (is_store && f3 < 3'd3) ||
                 (is_opimm && opimm_ok) || (is_op && op_ok) || is_fence);
  // Only SUB, SRA and SRAI set the alternate-op bit; shift-immediates carry it in f7
  assign sub = is_op ? f7[5] : (f3 == 3'b101 && f7[5]);
  always_comb begin
    dec.pc = pc_i;
    dec.rs1 = instr_i[19:15];
    dec.rs2 = instr_i[24:20];
    dec.rd = instr_i[11:7];
    dec.imm = (is_lui || is_auipc) ? imm_u : is_jal ? imm_j : (is_jalr || is_load || is_opimm) ? imm_i :
              is_store ? imm_s : is_br ? imm_b : 32'd0;
    dec.rf_we = legal && (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op) &&
                instr_i[11:7] != 5'd0;
    dec.use_pc = is_auipc || is_jal || is_br;
    dec.use_imm = is_lui || is_auipc || is_jal || is_jalr || is_br || is_load || is_store || is_opimm;
    dec.alu_func = (is_op && m_op) ? {2'b01, f3} : (is_op || is_opimm) ? {1'b0, sub, f3} :
                   is_lui ? 5'b10000 : 5'b00000;
    dec.ram_special = (is_load || is_store) ? {f3[2], f3[1:0], 1'b0} : 4'd0;
    dec.ram_wr = legal && is_store;
    dec.wb_source = (is_jal || is_jalr) ? 2'd1 : is_load ? 2'd2 : 2'd0;
    dec.br_cond = !(legal && is_br) ? 3'd0 : f3[2:1] == 2'b00 ? (f3[0] ? 3'd2 : 3'd1) : (f3[0] ? 3'd4 : 3'd5);
    dec.br_is_cond = legal && is_br;
    dec.br_unsigned = legal && is_br && f3[1];
    dec.br_jmp = legal && (is_jal || is_jalr);
    dec.illegal = !legal;
  end
  assign out_valid_o = state != EMPTY;
  // rdy_q doubles as an out-of-reset flag so the stage refuses input during reset
  assign in_ready_o = SKID ? rdy_q : rdy_q && (state == EMPTY || out_ready_i);
  assign acc_in = in_valid_i && in_ready_o;
  assign acc_out = out_valid_o && out_ready_i;
  always_comb begin
    state_n = state;
    out_n = out_r;
    skid_n = skid_r;
    case (state)
      EMPTY: if (acc_in) begin
        state_n = ONE;
        out_n = dec;
      end
      ONE: if (acc_in && !acc_out) begin
        state_n = TWO;
        skid_n = dec;
      end else if (acc_in) out_n = dec;
      else if (acc_out) state_n = EMPTY;
      TWO: if (acc_out) begin
        state_n = ONE;
        out_n = skid_r;
      end
      default: state_n = EMPTY;
    endcase
    if (flush_i) state_n = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
      out_r <= '0;
      skid_r <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      out_r <= out_n;
      skid_r <= skid_n;
      rdy_q <= !SKID || state_n != TWO;
    end
  end
  assign pc_o = out_r.pc;
  assign rs1_o = out_r.rs1;
  assign rs2_o = out_r.rs2;
  assign rd_o = out_r.rd;
  assign imm_o = out_r.imm;
  assign rf_write0_enable = out_r.rf_we;
  assign alu_op0_use_pc = out_r.use_pc;
  assign alu_op1_use_imm = out_r.use_imm;
  assign alu_func = out_r.alu_func;
  assign ram_special = out_r.ram_special;
  assign ram_wr = out_r.ram_wr;
  assign wb_source = out_r.wb_source;
  assign br_cond = out_r.br_cond;
  assign br_is_cond = out_r.br_is_cond;
  assign br_unsigned = out_r.br_unsigned;
  assign br_jmp = out_r.br_jmp;
  assign illegal_o = out_r.illegal;
endmodule

// File: tb/tb_rv32_mod_decode_stage.sv
// tb_rv32_mod_decode_stage: directed decode vectors plus skid, flush and reset sequences
module tb_rv32_mod_decode_stage;
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        upc;
    logic        uimm;
    logic [4:0]  af;
    logic [3:0]  rs;
    logic        rw;
    logic [1:0]  wb;
    logic [2:0]  bc;
    logic        bic;
    logic        bu;
    logic        bj;
    logic        ill;
  } dec_t;
  typedef struct {
    logic [31:0] instr;
    dec_t        exp;
    logic        full;
    logic        b_ill;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0;
  logic a_ready, a_valid, a_we, a_upc, a_uimm, a_rw, a_bic, a_bu, a_bj, a_ill;
  logic b_ready, b_valid, b_we, b_upc, b_uimm, b_rw, b_bic, b_bu, b_bj, b_ill;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [4:0] a_rs1, a_rs2, a_rd, a_af, b_rs1, b_rs2, b_rd, b_af;
  logic [3:0] a_rs, b_rs;
  logic [1:0] a_wb, b_wb;
  logic [2:0] a_bc, b_bc;
  dec_t a_obs, msk;
  vec_t vecs[19];
  int n_run = 0, n_fail = 0;
  assign a_obs = {a_imm, a_rs1, a_rs2, a_rd, a_we, a_upc, a_uimm, a_af, a_rs, a_rw, a_wb, a_bc, a_bic, a_bu, a_bj, a_ill};
  always #5 clk = ~clk;
  rv32_mod_decode_stage dut (
    .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(a_valid), .out_ready_i(out_ready), .pc_o(a_pc),
    .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd), .imm_o(a_imm), .rf_write0_enable(a_we),
    .alu_op0_use_pc(a_upc), .alu_op1_use_imm(a_uimm), .alu_func(a_af), .ram_special(a_rs),
    .ram_wr(a_rw), .wb_source(a_wb), .br_cond(a_bc), .br_is_cond(a_bic), .br_unsigned(a_bu),
    .br_jmp(a_bj), .illegal_o(a_ill)
  );
  rv32_mod_decode_stage #(.PC_W(32), .SKID(1'b0), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(b_valid), .out_ready_i(out_ready), .pc_o(b_pc),
    .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd), .imm_o(b_imm), .rf_write0_enable(b_we),
    .alu_op0_use_pc(b_upc), .alu_op1_use_imm(b_uimm), .alu_func(b_af), .ram_special(b_rs),
    .ram_wr(b_rw), .wb_source(b_wb), .br_cond(b_bc), .br_is_cond(b_bic), .br_unsigned(b_bu),
    .br_jmp(b_bj), .illegal_o(b_ill)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    vecs[0]  = '{32'h00500093, '{32'h00000005, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[1]  = '{32'hFE20CEE3, '{32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 1'b0, 1'b1, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[2]  = '{32'h022080B3, '{32'h00000000, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 5'b01000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b1};
    vecs[3]  = '{32'h123452B7, '{32'h12345000, 5'd8, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'b10000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[4]  = '{32'hFF812183, '{32'hFFFFFFF8, 5'd2, 5'd24, 5'd3, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b0100, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[5]  = '{32'h00532623, '{32'h0000000C, 5'd6, 5'd5, 5'd12, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b0100, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[6]  = '{32'h008000EF, '{32'h00000008, 5'd0, 5'd8, 5'd1, 1'b1, 1'b1, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b0};
    vecs[7]  = '{32'h00008067, '{32'h00000000, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1, 1'b0};
    vecs[8]  = '{32'h402081B3, '{32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'b01000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[9]  = '{32'h40325213, '{32'h00000403, 5'd4, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'b01101, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[10] = '{32'h0020F863, '{32'h00000010, 5'd1, 5'd2, 5'd16, 1'b0, 1'b1, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[11] = '{32'h00001517, '{32'h00001000, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[12] = '{32'h027352B3, '{32'h00000000, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 5'b01101, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b1};
    vecs[13] = '{32'h00015083, '{32'h00000000, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b1010, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[14] = '{32'h0FF0000F, '{32'h00000000, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 1'b0};
    vecs[15] = '{32'h00000073, '{32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1};
    vecs[16] = '{32'h00000001, '{32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1};
    vecs[17] = '{32'h02009093, '{32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1};
    vecs[18] = '{32'h00002063, '{32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1};
    msk = '0;
    msk.we = 1'b1;
    msk.rw = 1'b1;
    msk.bc = 3'b111;
    msk.bic = 1'b1;
    msk.bu = 1'b1;
    msk.bj = 1'b1;
    msk.ill = 1'b1;
    // reset held three cycles with valid input present
    in_valid = 1'b1;
    instr = 32'h00500093;
    pc = 32'h0000_0100;
    repeat (3) @(negedge clk);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_obs, '0);
    chk("rst_pc", a_pc, 32'd0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_ready_nm", b_ready, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", a_ready, 1'b1);
    chk("post_rst_ready_nm", b_ready, 1'b1);
    chk("post_rst_valid", a_valid, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      instr = vecs[i].instr;
      pc = 32'h0000_1000 + 32'(i * 4);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), a_valid, 1'b1);
      chk($sformatf("v%0d_bundle", i), vecs[i].full ? a_obs : (a_obs & msk), vecs[i].full ? vecs[i].exp : (vecs[i].exp & msk));
      chk($sformatf("v%0d_pc", i), a_pc, 32'h0000_1000 + 32'(i * 4));
      chk($sformatf("v%0d_ill_nm", i), b_ill, vecs[i].b_ill);
      chk($sformatf("v%0d_we_nm", i), b_we, vecs[i].b_ill ? 1'b0 : vecs[i].exp.we);
      @(negedge clk);
    end
    // backpressure: three offered, two held, then drained in order at one per cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00100093;
    @(negedge clk);
    chk("sk1_ready", a_ready, 1'b1);
    chk("sk1_valid", a_valid, 1'b1);
    chk("sk1_rd", a_rd, 5'd1);
    chk("sk1_ready_nm", b_ready, 1'b0);
    instr = 32'h00200113;
    @(negedge clk);
    chk("sk2_ready", a_ready, 1'b0);
    chk("sk2_rd", a_rd, 5'd1);
    instr = 32'h00300193;
    @(negedge clk);
    chk("sk3_ready", a_ready, 1'b0);
    chk("sk3_valid", a_valid, 1'b1);
    chk("sk3_rd", a_rd, 5'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("sk4_rd", a_rd, 5'd2);
    chk("sk4_valid", a_valid, 1'b1);
    chk("sk4_ready", a_ready, 1'b1);
    @(negedge clk);
    chk("sk5_rd", a_rd, 5'd3);
    chk("sk5_imm", a_imm, 32'd3);
    chk("sk5_valid", a_valid, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sk6_valid", a_valid, 1'b0);
    chk("sk6_valid_nm", b_valid, 1'b0);
    // flush while full with a third instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00400213;
    @(negedge clk);
    instr = 32'h00500293;
    @(negedge clk);
    chk("fl_two_ready", a_ready, 1'b0);
    instr = 32'h00600313;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", a_valid, 1'b0);
    chk("fl_valid_nm", b_valid, 1'b0);
    chk("fl_ready", a_ready, 1'b1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_after_valid", a_valid, 1'b0);
    chk("fl_after_valid_nm", b_valid, 1'b0);
    // flush coinciding with a handshake from empty
    in_valid = 1'b1;
    flush = 1'b1;
    instr = 32'h00400213;
    @(negedge clk);
    chk("flhs_valid", a_valid, 1'b0);
    chk("flhs_valid_nm", b_valid, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    // back-to-back stream: both variants accept and emit in the same cycle
    in_valid = 1'b1;
    instr = 32'h00100093;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("st%0d_valid", k), a_valid, 1'b1);
      chk($sformatf("st%0d_rd", k), a_rd, 5'(k));
      chk($sformatf("st%0d_valid_nm", k), b_valid, 1'b1);
      chk($sformatf("st%0d_rd_nm", k), b_rd, 5'(k));
      chk($sformatf("st%0d_ready_nm", k), b_ready, 1'b1);
      if (k == 1) instr = 32'h00200113;
      else if (k == 2) instr = 32'h00300193;
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("st_end_valid", a_valid, 1'b0);
    chk("st_end_valid_nm", b_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
